debug_frame_serializer: RTL and testbench
=========================================

// Module: debug_frame_serializer
// PURPOSE
//   Command-driven debug dump engine between uart_rx/uart_tx and the pipeline.
//   One command byte from uart_rx selects one of NUM_CH snapshot channels
//   (for example IF_ID, ID_EX, EX_MEM, MEM_WB, or register/memory read data).
//   The selected channel is latched and sent to uart_tx as a byte frame.
//   It replaces fixed-width, per-latch dump logic with one parametrised engine.
// PARAMETERS
//   NB_DATA    8    UART byte width
//   NUM_CH     4    number of snapshot channels (1..2**NB_DATA)
//   NB_CH      168  bit width of each channel
//   LSB_FIRST  1    1: least-significant payload byte sent first; 0: most-significant byte first
// PORTS
//   i_clk         in   1               system clock
//   i_reset       in   1               asynchronous reset, active-high
//   i_rx_done     in   1               1-cycle pulse; i_rx_data holds a valid command
//   i_rx_data     in   NB_DATA         command byte
//   i_tx_done     in   1               1-cycle pulse; uart_tx has finished the current byte
//   o_tx_data     out  NB_DATA         byte to transmit
//   o_tx_start    out  1               1-cycle pulse; starts transmission of o_tx_data
//   i_channels    in   NUM_CH*NB_CH    packed channels; channel k = [k*NB_CH +: NB_CH]
//   o_busy        out  1               high from command acceptance until the last byte's i_tx_done
//   o_cmd_error   out  1               1-cycle pulse; command value >= NUM_CH
//   o_overrun     out  1               1-cycle pulse; i_rx_done arrived while o_busy
// BEHAVIOUR
//   Frame sizing
//   - NBYTES = ceil(NB_CH/NB_DATA).
//   - The final payload byte is zero-padded in its unused MSBs.
//   - Frame = header (the command byte echoed), then NBYTES payload bytes,
//     then the checksum byte if DBG_CHECKSUM_EN is defined.
//   Reset
//   - Async assert: o_tx_data=0, o_tx_start=0, o_busy=0, o_cmd_error=0, o_overrun=0.
//   - FSM goes to IDLE; byte counter and snapshot register clear.
//   - Reset mid-frame aborts the frame immediately; no further o_tx_start is issued.
//   FSM states
//   - IDLE: on i_rx_done with i_rx_data < NUM_CH:
//       latch the full channel into the snapshot register;
//       latch the command; set o_busy=1; go to START.
//     On i_rx_done with i_rx_data >= NUM_CH: pulse o_cmd_error next cycle, stay in IDLE.
//   - START: drive o_tx_data with the current byte, pulse o_tx_start for one cycle, go to WAIT.
//   - WAIT: hold o_tx_data stable until i_tx_done.
//       If that was the last byte: o_busy=0 the next cycle, go to IDLE.
//       Otherwise: increment the byte index and go to START.
//   Latency and timing
//   - First o_tx_start comes 2 cycles after the i_rx_done cycle (IDLE->START, START->pulse).
//   - The next o_tx_start comes 2 cycles after each i_tx_done.
//   - Payload comes only from the snapshot. Changes on i_channels after acceptance
//     do not affect the frame in flight.
//   Boundary conditions
//   - i_rx_done while busy: the command is dropped, o_overrun pulses, the frame continues unchanged.
//   - i_rx_done in the same cycle as the final i_tx_done: treated as busy (dropped, overrun).
//   - i_tx_done outside WAIT is ignored.
//   - NB_CH an exact multiple of NB_DATA: no padding.
//   - NUM_CH=1: only command 0 is valid.
//   Byte order
//   - LSB_FIRST=1: payload byte i = snapshot[i*NB_DATA +: NB_DATA].
//   - LSB_FIRST=0: payload byte order is reversed (padded byte first).
// CONFIGURATION
//   DBG_CHECKSUM_EN defined
//   - One extra byte after the payload: XOR of the header and all payload bytes (padding included).
//   - Frame length = NBYTES+2.
//   DBG_CHECKSUM_EN undefined
//   - No checksum logic; frame length = NBYTES+1.
// TESTING (bench: NB_CH=20, NUM_CH=4, LSB_FIRST=1; uart_tx model returns i_tx_done 10 cycles after o_tx_start)
//   1. ch2=20'hABCDE, cmd 8'h02
//      -> tx bytes 02, DE, BC, 0A (checksum build adds 6A); o_busy drops after the last i_tx_done.
//   2. cmd 8'h07
//      -> o_cmd_error pulses once; no o_tx_start; o_busy stays 0.
//   3. Change ch2 to 20'h12345 one cycle after acceptance of cmd 02
//      -> payload still DE, BC, 0A.
//   4. Second i_rx_done (cmd 01) during a frame
//      -> o_overrun pulses once; frame unchanged; no ch1 frame follows.
//   5. Assert i_reset while waiting for the 2nd byte's i_tx_done
//      -> all outputs 0 at once; a new cmd 00 afterwards yields a clean frame starting 00.
//   6. LSB_FIRST=0 rebuild, ch2=20'hABCDE, cmd 02
//      -> tx bytes 02, 0A, BC, DE.

Source files
------------

// File: rtl/debug_frame_serializer.sv
// debug_frame_serializer
//   Command-driven debug dump engine. A command byte from the UART receiver
//   selects one of NUM_CH snapshot channels. The channel is latched and then
//   sent to the UART transmitter as a frame:
//     header (command echo), NBYTES payload bytes, optional checksum byte.
//   Optional feature macro: DBG_CHECKSUM_EN. When it is defined, a trailing
//   byte is sent that is the XOR of the header and all payload bytes.
// Ports
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_rx_done, i_rx_data      command strobe and command byte
//   i_tx_done                 transmitter finished the current byte
//   o_tx_data, o_tx_start     byte to send and its one-cycle start pulse
//   i_channels                packed channels; channel k = [k*NB_CH +: NB_CH]
//   o_busy                    frame in progress
//   o_cmd_error, o_overrun    one-cycle pulses: bad command / command while busy
module debug_frame_serializer #(
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned NB_CH     = 168,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_rx_done,
  input  logic [NB_DATA-1:0]        i_rx_data,
  input  logic                      i_tx_done,
  output logic [NB_DATA-1:0]        o_tx_data,
  output logic                      o_tx_start,
  input  logic [NUM_CH*NB_CH-1:0]   i_channels,
  output logic                      o_busy,
  output logic                      o_cmd_error,
  output logic                      o_overrun
);

  localparam int unsigned NBYTES = (NB_CH + NB_DATA - 1) / NB_DATA;
  localparam int unsigned SNAP_W = NBYTES * NB_DATA;
`ifdef DBG_CHECKSUM_EN
  localparam int unsigned FLEN   = NBYTES + 2;
`else
  localparam int unsigned FLEN   = NBYTES + 1;
`endif
  localparam int unsigned IDX_W  = $clog2(FLEN);
  localparam int unsigned CMD_W  = NB_DATA + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SNAP_W-1:0]    snap_q, snap_d;
  logic [NB_DATA-1:0]   cmd_q, cmd_d;
  logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 overrun_q, overrun_d;
`ifdef DBG_CHECKSUM_EN
  logic [NB_DATA-1:0]   csum_q, csum_d;
`endif

  logic                 cmd_valid_c;
  logic [NB_CH-1:0]     chan_sel_c;
  logic [NB_DATA-1:0]   payload_c;
  logic [NB_DATA-1:0]   cur_byte_c;

  // Command range check; extra bit lets NUM_CH reach 2**NB_DATA.
  assign cmd_valid_c = ({1'b0, i_rx_data} < CMD_W'(NUM_CH));

  // Channel mux addressed by the incoming command.
  always_comb begin
    chan_sel_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_rx_data == NB_DATA'(k)) chan_sel_c = i_channels[k*NB_CH +: NB_CH];
    end
  end

  // Payload byte for frame index idx_q (index 0 is the header).
  always_comb begin
    payload_c = '0;
    for (int j = 0; j < NBYTES; j++) begin
      int pos;
      pos = (LSB_FIRST != 0) ? j : (int'(NBYTES) - 1 - j);
      if (idx_q == IDX_W'(j + 1)) payload_c = snap_q[pos*NB_DATA +: NB_DATA];
    end
  end

  // Byte selection across header / payload / checksum.
  always_comb begin
    cur_byte_c = payload_c;
    if (idx_q == '0) begin
      cur_byte_c = cmd_q;
    end
`ifdef DBG_CHECKSUM_EN
    else if (idx_q == LAST_IDX) begin
      cur_byte_c = csum_q;
    end
`endif
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    cmd_d      = cmd_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    cmd_err_d  = 1'b0;
    overrun_d  = 1'b0;
`ifdef DBG_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_rx_done) begin
          if (cmd_valid_c) begin
            snap_d  = SNAP_W'(chan_sel_c);
            cmd_d   = i_rx_data;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = S_START;
`ifdef DBG_CHECKSUM_EN
            csum_d  = '0;
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_START: begin
        tx_data_d  = cur_byte_c;
        tx_start_d = 1'b1;
        state_d    = S_WAIT;
`ifdef DBG_CHECKSUM_EN
        // Accumulated as bytes go out; the checksum slot itself never reaches here before use.
        csum_d     = csum_q ^ cur_byte_c;
`endif
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_START;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Commands arriving mid-frame (including on the final i_tx_done) are dropped.
    if (i_rx_done && busy_q) overrun_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      snap_q     <= '0;
      cmd_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef DBG_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      cmd_q      <= cmd_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      cmd_err_q  <= cmd_err_d;
      overrun_q  <= overrun_d;
`ifdef DBG_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;
  assign o_cmd_error = cmd_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_debug_frame_serializer.sv
// Testbench for debug_frame_serializer (NB_CH=20, NUM_CH=4).
// Instance a: LSB_FIRST=1, instance b: LSB_FIRST=0.
module tb_debug_frame_serializer;

  localparam int NB_DATA = 8;
  localparam int NUM_CH  = 4;
  localparam int NB_CH   = 20;
`ifdef DBG_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_done = 1'b0;
  logic rx_done_b = 1'b0;
  logic [7:0] rx_data = '0;
  logic tx_done = 1'b0;
  logic tx_done_b = 1'b0;
  logic [19:0] ch [NUM_CH];
  logic [NUM_CH*NB_CH-1:0] channels;

  logic [7:0] tx_data, tx_data_b;
  logic tx_start, tx_start_b, busy, busy_b, cmd_err, cmd_err_b, ovr, ovr_b;

  int total = 0;
  int bad = 0;
  int n_err = 0;
  int n_ovr = 0;
  int cnt = 0;
  int cnt_b = 0;
  logic [7:0] q[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;
  assign channels = {ch[3], ch[2], ch[1], ch[0]};

  debug_frame_serializer #(.NB_DATA(NB_DATA), .NUM_CH(NUM_CH), .NB_CH(NB_CH), .LSB_FIRST(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_tx_done(tx_done), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_channels(channels), .o_busy(busy), .o_cmd_error(cmd_err), .o_overrun(ovr));

  debug_frame_serializer #(.NB_DATA(NB_DATA), .NUM_CH(NUM_CH), .NB_CH(NB_CH), .LSB_FIRST(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_rx_done(rx_done_b), .i_rx_data(rx_data),
    .i_tx_done(tx_done_b), .o_tx_data(tx_data_b), .o_tx_start(tx_start_b),
    .i_channels(channels), .o_busy(busy_b), .o_cmd_error(cmd_err_b), .o_overrun(ovr_b));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // UART transmitter models: i_tx_done 10 cycles after each o_tx_start.
  always @(negedge clk) begin
    if (rst) begin
      cnt = 0;
      tx_done = 1'b0;
    end else begin
      tx_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_done = 1'b1;
          if (q.size() > 0) chk("tx_data_hold", 32'(tx_data), 32'(q[q.size()-1]));
        end
      end
      if (tx_start) begin
        q.push_back(tx_data);
        cnt = 10;
      end
      if (cmd_err) n_err++;
      if (ovr) n_ovr++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      cnt_b = 0;
      tx_done_b = 1'b0;
    end else begin
      tx_done_b = 1'b0;
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) tx_done_b = 1'b1;
      end
      if (tx_start_b) begin
        q_b.push_back(tx_data_b);
        cnt_b = 10;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    rx_data = c;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic set_bg();
    ch[0] = 20'h44444;
    ch[1] = 20'h33333;
    ch[2] = 20'h22222;
    ch[3] = 20'h11111;
  endtask

  // Compares a captured frame with header c, payload p0..p2 and optional checksum.
  task automatic chk_frame(input string name, input logic [7:0] got[$],
                           input logic [7:0] c, input logic [7:0] p0,
                           input logic [7:0] p1, input logic [7:0] p2);
    logic [7:0] e [5];
    logic [7:0] g;
    e[0] = c; e[1] = p0; e[2] = p1; e[3] = p2;
    e[4] = c ^ p0 ^ p1 ^ p2;
    chk({name, "_len"}, 32'(got.size()), 32'(FLEN));
    for (int i = 0; i < FLEN; i++) begin
      if (i < got.size()) g = got[i];
      else g = 8'hxx;
      chk($sformatf("%s_byte%0d", name, i), 32'(g), 32'(e[i]));
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [19:0] val;
    logic        err;
    logic [7:0]  p0, p1, p2;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int e0, o0, qs;
    vecs[0] = '{8'h02, 20'hABCDE, 1'b0, 8'hDE, 8'hBC, 8'h0A};
    vecs[1] = '{8'h00, 20'h00000, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{8'h01, 20'hFFFFF, 1'b0, 8'hFF, 8'hFF, 8'h0F};
    vecs[3] = '{8'h03, 20'h12345, 1'b0, 8'h45, 8'h23, 8'h01};
    vecs[4] = '{8'h07, 20'h00000, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{8'h04, 20'h00000, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{8'hFF, 20'h00000, 1'b1, 8'h00, 8'h00, 8'h00};

    set_bg();
    repeat (3) tick();
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("rst_overrun", 32'(ovr), 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: latency, busy timing and frame contents for cmd 02.
    ch[2] = 20'hABCDE;
    q.delete();
    send_cmd(8'h02);
    chk("t1_busy_accept", 32'(busy), 32'd1);
    chk("t1_no_early_start", 32'(tx_start), 32'd0);
    tick();
    chk("t1_first_start", 32'(tx_start), 32'd1);
    chk("t1_first_byte", 32'(tx_data), 32'h02);
    begin
      int n;
      n = 0;
      while (!(tx_done && q.size() == FLEN) && n < 400) begin
        tick();
        n++;
      end
      chk("t1_last_done_seen", 32'(tx_done), 32'd1);
      chk("t1_busy_at_last_done", 32'(busy), 32'd1);
      tick();
      chk("t1_busy_after_last_done", 32'(busy), 32'd0);
    end
    chk_frame("t1", q, 8'h02, 8'hDE, 8'hBC, 8'h0A);

    // Table: valid commands produce frames, invalid ones pulse o_cmd_error.
    for (int v = 0; v < 7; v++) begin
      set_bg();
      if (!vecs[v].err) ch[vecs[v].cmd[1:0]] = vecs[v].val;
      q.delete();
      e0 = n_err;
      send_cmd(vecs[v].cmd);
      if (vecs[v].err) begin
        chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
        repeat (15) tick();
        chk($sformatf("vec%0d_err_pulses", v), 32'(n_err - e0), 32'd1);
        chk($sformatf("vec%0d_no_tx", v), 32'(q.size()), 32'd0);
        chk($sformatf("vec%0d_busy_after", v), 32'(busy), 32'd0);
      end else begin
        wait_idle($sformatf("vec%0d", v));
        repeat (2) tick();
        chk($sformatf("vec%0d_no_err", v), 32'(n_err - e0), 32'd0);
        chk_frame($sformatf("vec%0d", v), q, vecs[v].cmd, vecs[v].p0, vecs[v].p1, vecs[v].p2);
      end
    end

    // Test 3: channel change right after acceptance does not alter the frame.
    set_bg();
    ch[2] = 20'hABCDE;
    q.delete();
    send_cmd(8'h02);
    ch[2] = 20'h12345;
    wait_idle("t3");
    repeat (2) tick();
    chk_frame("t3", q, 8'h02, 8'hDE, 8'hBC, 8'h0A);

    // Test 4: commands mid-frame and on the final i_tx_done are dropped.
    set_bg();
    ch[2] = 20'hABCDE;
    ch[1] = 20'h55555;
    q.delete();
    o0 = n_ovr;
    send_cmd(8'h02);
    repeat (5) tick();
    send_cmd(8'h01);
    chk("t4_overrun_mid", 32'(n_ovr - o0), 32'd1);
    begin
      int n;
      n = 0;
      while (!(tx_done && q.size() == FLEN) && n < 400) begin
        tick();
        n++;
      end
      chk("t4_last_done_seen", 32'(tx_done), 32'd1);
    end
    send_cmd(8'h00);
    chk("t4_overrun_final", 32'(n_ovr - o0), 32'd2);
    repeat (30) tick();
    chk("t4_busy_after", 32'(busy), 32'd0);
    chk_frame("t4", q, 8'h02, 8'hDE, 8'hBC, 8'h0A);

    // Test 5: reset while waiting for the 2nd byte's i_tx_done.
    q.delete();
    send_cmd(8'h02);
    begin
      int n;
      n = 0;
      while (q.size() < 2 && n < 400) begin
        tick();
        n++;
      end
    end
    repeat (3) tick();
    chk("t5_busy_before", 32'(busy), 32'd1);
    chk("t5_data_before", 32'(tx_data), 32'hDE);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t5_rst_tx_start", 32'(tx_start), 32'd0);
    chk("t5_rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("t5_rst_overrun", 32'(ovr), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    qs = q.size();
    repeat (30) tick();
    chk("t5_no_start_after_rst", 32'(q.size()), 32'(qs));
    ch[0] = 20'h5A3C1;
    q.delete();
    send_cmd(8'h00);
    wait_idle("t5");
    repeat (2) tick();
    chk_frame("t5", q, 8'h00, 8'hC1, 8'hA3, 8'h05);

    // Test 6: MSB-first instance.
    set_bg();
    ch[2] = 20'hABCDE;
    q_b.delete();
    rx_data = 8'h02;
    rx_done_b = 1'b1;
    tick();
    rx_done_b = 1'b0;
    chk("t6_busy_accept", 32'(busy_b), 32'd1);
    begin
      int n;
      n = 0;
      while (busy_b && n < 400) begin
        tick();
        n++;
      end
      chk("t6_idle_timeout", 32'(busy_b), 32'd0);
    end
    repeat (2) tick();
    chk_frame("t6", q_b, 8'h02, 8'h0A, 8'hBC, 8'hDE);
    chk("t6_no_tx_on_a", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
